// File: rtl/rv32m_muldiv.sv
// rv32m_muldiv: iterative RISC-V M-extension unit (MUL/MULH/MULHSU/MULHU,
// DIV/DIVU/REM/REMU) that sits beside the EX-stage ALU.
//
// Ports:
//   clk     in   clock, all state changes on the rising edge
//   rst     in   synchronous active-high reset
//   start   in   issue request, accepted only while busy=0 and flush=0
//   flush   in   kills any in-flight operation, no done is produced
//   funct3  in   M-extension funct3, captured on an accepted start
//   ain     in   rs1 (multiplicand / dividend), captured on accept
//   bin     in   rs2 (multiplier / divisor), captured on accept
//   busy    out  high while iterating (W cycles)
//   done    out  one-cycle result-valid pulse
//   dout    out  result, holds the last value until the next done
//
// Multiplies use radix-2 shift-add on operand magnitudes; divides use a
// restoring divider on magnitudes. Signs are applied when the last
// iteration's result is registered into dout. Divide-by-zero and signed
// overflow bypass the iteration and complete in one cycle.
module rv32m_muldiv #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  flush,
    input  logic [2:0]            funct3,
    input  logic [DATA_WIDTH-1:0] ain,
    input  logic [DATA_WIDTH-1:0] bin,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] dout
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_n_s;
    logic [CW-1:0]   cnt_r;
    logic            is_div_r;
    logic [1:0]      op_r;
    logic            neg_res_r;     // negate product / quotient
    logic            neg_rem_r;     // remainder follows dividend sign
    logic [W-1:0]    opnd_r;        // multiplicand or divisor magnitude
    logic [2*W-1:0]  acc_r;         // mul: {high, low/multiplier}; div: low = dividend/quotient
    logic [W-1:0]    rem_r;         // restored remainder, always < divisor
    logic            busy_r;
    logic            done_r;
    logic [W-1:0]    dout_r;

    logic            busy_n_s;
    logic            done_n_s;
    logic [W-1:0]    dout_n_s;
    logic            load_s;
    logic            step_s;

    // Operand decode for an incoming request
    logic            a_signed_s;
    logic            b_signed_s;
    logic            neg_a_s;
    logic            neg_b_s;
    logic [W-1:0]    mag_a_s;
    logic [W-1:0]    mag_b_s;
    logic            div0_s;
    logic            ovf_s;
    logic            fast_s;
    logic [W-1:0]    fast_val_s;

    // Iteration datapath
    logic [W:0]      mul_sum_s;
    logic [2*W-1:0]  mul_next_s;
    logic [W:0]      div_shift_s;   // W+1-bit partial remainder trial value
    logic            div_ge_s;
    logic [W-1:0]    div_diff_s;
    logic [W-1:0]    rem_next_s;
    logic [W-1:0]    quo_next_s;
    logic [2*W-1:0]  prod_fix_s;
    logic [W-1:0]    quo_fix_s;
    logic [W-1:0]    rem_fix_s;
    logic [W-1:0]    calc_res_s;

    assign busy = busy_r;
    assign done = done_r;
    assign dout = dout_r;

    // Decode operand signedness, magnitudes and the one-cycle special cases
    always_comb begin
        // rs1 is unsigned only for MULHU/DIVU/REMU
        a_signed_s = ~(funct3[0] & (funct3[1] | funct3[2]));
        // rs2 is unsigned for MULHSU/MULHU/DIVU/REMU
        b_signed_s = funct3[2] ? ~funct3[0] : ~funct3[1];
        neg_a_s    = a_signed_s & ain[W-1];
        neg_b_s    = b_signed_s & bin[W-1];
        mag_a_s    = neg_a_s ? ({W{1'b0}} - ain) : ain;
        mag_b_s    = neg_b_s ? ({W{1'b0}} - bin) : bin;
        div0_s     = funct3[2] & (bin == {W{1'b0}});
        ovf_s      = funct3[2] & ~funct3[0] &
                     (ain == {1'b1, {(W-1){1'b0}}}) & (bin == {W{1'b1}});
        fast_s     = div0_s | ovf_s;
        if (div0_s) begin
            fast_val_s = funct3[1] ? ain : {W{1'b1}};
        end else begin
            fast_val_s = funct3[1] ? {W{1'b0}} : ain;
        end
    end

    // One shift-add / restoring-divide iteration and sign correction
    always_comb begin
        mul_sum_s   = {1'b0, acc_r[2*W-1:W]} +
                      (acc_r[0] ? {1'b0, opnd_r} : {(W+1){1'b0}});
        mul_next_s  = {mul_sum_s, acc_r[W-1:1]};
        div_shift_s = {rem_r, acc_r[W-1]};
        div_ge_s    = (div_shift_s >= {1'b0, opnd_r});
        // When the trial succeeds the true difference is below the divisor,
        // so the low W bits are exact.
        div_diff_s  = div_shift_s[W-1:0] - opnd_r;
        rem_next_s  = div_ge_s ? div_diff_s : div_shift_s[W-1:0];
        quo_next_s  = {acc_r[W-2:0], div_ge_s};
        prod_fix_s  = neg_res_r ? ({(2*W){1'b0}} - mul_next_s) : mul_next_s;
        quo_fix_s   = neg_res_r ? ({W{1'b0}} - quo_next_s) : quo_next_s;
        rem_fix_s   = neg_rem_r ? ({W{1'b0}} - rem_next_s) : rem_next_s;
        case ({is_div_r, op_r})
            3'b000:  calc_res_s = prod_fix_s[W-1:0];
            3'b001:  calc_res_s = prod_fix_s[2*W-1:W];
            3'b010:  calc_res_s = prod_fix_s[2*W-1:W];
            3'b011:  calc_res_s = prod_fix_s[2*W-1:W];
            3'b100:  calc_res_s = quo_fix_s;
            3'b101:  calc_res_s = quo_fix_s;
            3'b110:  calc_res_s = rem_fix_s;
            3'b111:  calc_res_s = rem_fix_s;
            default: calc_res_s = {W{1'b0}};
        endcase
    end

    // Next-state and next-output logic; flush overrides everything
    always_comb begin
        state_n_s = state_r;
        busy_n_s  = 1'b0;
        done_n_s  = 1'b0;
        dout_n_s  = dout_r;
        load_s    = 1'b0;
        step_s    = 1'b0;
        if (flush) begin
            state_n_s = S_IDLE;
        end else begin
            case (state_r)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        if (fast_s) begin
                            state_n_s = S_DONE;
                            done_n_s  = 1'b1;
                            dout_n_s  = fast_val_s;
                        end else begin
                            state_n_s = S_CALC;
                            busy_n_s  = 1'b1;
                            load_s    = 1'b1;
                        end
                    end else begin
                        state_n_s = S_IDLE;
                    end
                end
                S_CALC: begin
                    step_s = 1'b1;
                    if (cnt_r == CNT_LAST) begin
                        state_n_s = S_DONE;
                        done_n_s  = 1'b1;
                        dout_n_s  = calc_res_s;
                    end else begin
                        busy_n_s  = 1'b1;
                    end
                end
                default: begin
                    state_n_s = S_IDLE;
                end
            endcase
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_n_s;
        end
    end

    // Registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
            dout_r <= {W{1'b0}};
        end else begin
            busy_r <= busy_n_s;
            done_r <= done_n_s;
            dout_r <= dout_n_s;
        end
    end

    // Operand latch, iteration counter and accumulators
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r     <= {CW{1'b0}};
            is_div_r  <= 1'b0;
            op_r      <= 2'b00;
            neg_res_r <= 1'b0;
            neg_rem_r <= 1'b0;
            opnd_r    <= {W{1'b0}};
            acc_r     <= {(2*W){1'b0}};
            rem_r     <= {W{1'b0}};
        end else if (load_s) begin
            cnt_r     <= {CW{1'b0}};
            is_div_r  <= funct3[2];
            op_r      <= funct3[1:0];
            neg_res_r <= neg_a_s ^ neg_b_s;
            neg_rem_r <= neg_a_s;
            rem_r     <= {W{1'b0}};
            if (funct3[2]) begin
                opnd_r <= mag_b_s;
                acc_r  <= {{W{1'b0}}, mag_a_s};
            end else begin
                opnd_r <= mag_a_s;
                acc_r  <= {{W{1'b0}}, mag_b_s};
            end
        end else if (step_s) begin
            cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
            if (is_div_r) begin
                acc_r <= {acc_r[2*W-1:W], quo_next_s};
                rem_r <= rem_next_s;
            end else begin
                acc_r <= mul_next_s;
                rem_r <= rem_r;
            end
        end else begin
            cnt_r <= cnt_r;
            acc_r <= acc_r;
            rem_r <= rem_r;
        end
    end

endmodule
